// File: rtl/vga_scan_counter.sv
// ============================================================================
// Module   : vga_scan_counter
// Brief    : Raster position generator with pixel-rate divider and strobes.
//            Optional frame counter enabled by VGA_SCAN_FRAME_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module vga_scan_counter #(
    parameter int CLK_DIV  = 4,
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        Enable,
    output logic [15:0] XAxis,
    output logic [15:0] YAxis,
    output logic        PixelTick,
    output logic        LineEnd,
    output logic        FrameEnd,
    output logic        FrameUpdate,
    output logic [15:0] FrameCount
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] c_div_last     = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] c_div_zero     = '0;
    localparam logic [DIV_W-1:0] c_div_one      = DIV_W'(1);
    localparam logic [15:0]      c_x_last       = 16'(H_TOTAL - 1);
    localparam logic [15:0]      c_y_last       = 16'(V_TOTAL - 1);
    localparam logic [15:0]      c_y_active_end = 16'(V_ACTIVE - 1);

    // Elaboration-time guard against configurations the counters cannot represent.
    generate
        if ((CLK_DIV < 1) || (CLK_DIV > 16) ||
            (H_TOTAL < 2) || (H_TOTAL > 65536) ||
            (V_TOTAL < 2) || (V_TOTAL > 65536) ||
            (H_ACTIVE < 1) || (H_ACTIVE > H_TOTAL) ||
            (V_ACTIVE < 1) || (V_ACTIVE >= V_TOTAL)) begin : g_bad_cfg
            $error("vga_scan_counter: illegal timing parameters");
        end
    endgenerate

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [15:0]      x_q, x_d;
    logic [15:0]      y_q, y_d;
    logic             frame_update_q, frame_update_d;

    logic w_div_last;
    logic w_pixel_tick;
    logic w_x_wrap;
    logic w_y_wrap;
    logic w_line_end;
    logic w_frame_end;

    always_comb begin
        w_div_last   = (div_cnt_q == c_div_last);
        w_pixel_tick = Enable & w_div_last;
        w_x_wrap     = (x_q == c_x_last);
        w_y_wrap     = (y_q == c_y_last);
        w_line_end   = w_pixel_tick & w_x_wrap;
        w_frame_end  = w_line_end & w_y_wrap;
    end

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (Enable) begin
            div_cnt_d = w_div_last ? c_div_zero : (div_cnt_q + c_div_one);
        end
    end

    // Y only moves on the X wrap, so both counters hang off the same tick.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (w_pixel_tick) begin
            if (w_x_wrap) begin
                x_d = 16'd0;
                y_d = w_y_wrap ? 16'd0 : (y_q + 16'd1);
            end else begin
                x_d = x_q + 16'd1;
            end
        end
    end

    // Fires on the step from the last active line into the first blank line.
    always_comb begin
        frame_update_d = w_line_end & (y_q == c_y_active_end);
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            div_cnt_q      <= '0;
            x_q            <= 16'd0;
            y_q            <= 16'd0;
            frame_update_q <= 1'b0;
        end else begin
            div_cnt_q      <= div_cnt_d;
            x_q            <= x_d;
            y_q            <= y_d;
            frame_update_q <= frame_update_d;
        end
    end

`ifdef VGA_SCAN_FRAME_COUNT_EN
    logic [15:0] frame_count_q, frame_count_d;

    always_comb begin
        frame_count_d = frame_count_q;
        if (w_frame_end) begin
            frame_count_d = frame_count_q + 16'd1;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_count_q <= 16'd0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign FrameCount = frame_count_q;
`else
    assign FrameCount = 16'd0;
`endif

    assign XAxis       = x_q;
    assign YAxis       = y_q;
    assign PixelTick   = w_pixel_tick;
    assign LineEnd     = w_line_end;
    assign FrameEnd    = w_frame_end;
    assign FrameUpdate = frame_update_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_scan_counter.sv
// ============================================================================
// Module   : tb_vga_scan_counter
// Brief    : Directed self-checking bench for vga_scan_counter on a reduced
//            16x10 frame (12x7 active), CLK_DIV=4 and CLK_DIV=1 instances.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vga_scan_counter;

    localparam int H_T = 16;
    localparam int V_T = 10;
    localparam int H_A = 12;
    localparam int V_A = 7;

`ifdef VGA_SCAN_FRAME_COUNT_EN
    localparam int FC_AFTER_FIRST = 1;
`else
    localparam int FC_AFTER_FIRST = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic        en;

    logic [15:0] x4, y4, fc4;
    logic        pt4, le4, fe4, fu4;
    logic [15:0] x1, y1, fc1;
    logic        pt1, le1, fe1, fu1;

    int tests_run    = 0;
    int tests_failed = 0;

    vga_scan_counter #(
        .CLK_DIV (4),
        .H_TOTAL (H_T),
        .V_TOTAL (V_T),
        .H_ACTIVE(H_A),
        .V_ACTIVE(V_A)
    ) u_dut4 (
        .Clock      (clk),
        .Reset_n    (rst_n),
        .Enable     (en),
        .XAxis      (x4),
        .YAxis      (y4),
        .PixelTick  (pt4),
        .LineEnd    (le4),
        .FrameEnd   (fe4),
        .FrameUpdate(fu4),
        .FrameCount (fc4)
    );

    vga_scan_counter #(
        .CLK_DIV (1),
        .H_TOTAL (H_T),
        .V_TOTAL (V_T),
        .H_ACTIVE(H_A),
        .V_ACTIVE(V_A)
    ) u_dut1 (
        .Clock      (clk),
        .Reset_n    (rst_n),
        .Enable     (en),
        .XAxis      (x1),
        .YAxis      (y1),
        .PixelTick  (pt1),
        .LineEnd    (le1),
        .FrameEnd   (fe1),
        .FrameUpdate(fu1),
        .FrameCount (fc1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Advance until the CLK_DIV=4 instance shows a tick at (x, y).
    task automatic run_to(input int x, input int y);
        int n;
        n = 0;
        while (!(pt4 && (32'(x4) == x) && (32'(y4) == y)) && (n < 3000)) begin
            step();
            n++;
        end
        check("run_to_found", 32'(pt4 && (32'(x4) == x) && (32'(y4) == y)), 32'd1);
    endtask

    initial begin
        int pulses;
        int first_pos;
        int second_pos;
        int ticks;
        int n;

        rst_n = 1'b0;
        en    = 1'b0;
        repeat (3) step();

        check("rst_x",  32'(x4),  32'd0);
        check("rst_y",  32'(y4),  32'd0);
        check("rst_pt", 32'(pt4), 32'd0);
        check("rst_fu", 32'(fu4), 32'd0);
        check("rst_fc", 32'(fc4), 32'd0);

        // Release: ticks expected on cycles 3, 7, 11; X counts completed ticks.
        en    = 1'b1;
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            check("start_tick", 32'(pt4), 32'((cyc % 4) == 3));
            check("start_x",    32'(x4),  32'(cyc / 4));
            check("start_y",    32'(y4),  32'd0);
            step();
        end

        run_to(15, 0);
        check("line_le", 32'(le4), 32'd1);
        check("line_fe", 32'(fe4), 32'd0);
        step();
        check("line_next_x", 32'(x4), 32'd0);
        check("line_next_y", 32'(y4), 32'd1);

        run_to(15, 9);
        check("frame_pt", 32'(pt4), 32'd1);
        check("frame_le", 32'(le4), 32'd1);
        check("frame_fe", 32'(fe4), 32'd1);
        check("frame_fc_before", 32'(fc4), 32'd0);
        step();
        check("frame_next_x", 32'(x4), 32'd0);
        check("frame_next_y", 32'(y4), 32'd0);
        check("frame_fc_after", 32'(fc4), 32'(FC_AFTER_FIRST));

        // Frame = 16*10*4 = 640 clocks. Tick at (15,6) is tick #111 -> cycle
        // 111*4+3 = 447; FrameUpdate is visible on cycle 448 at (0,7).
        pulses     = 0;
        first_pos  = -1;
        second_pos = -1;
        for (int c = 0; c < 1280; c++) begin
            if (fu4) begin
                pulses++;
                if (first_pos < 0) begin
                    first_pos = c;
                    check("fu_x", 32'(x4), 32'd0);
                    check("fu_y", 32'(y4), 32'(V_A));
                end else if (second_pos < 0) begin
                    second_pos = c;
                end
            end
            step();
        end
        check("fu_pulses", 32'(pulses), 32'd2);
        check("fu_first_pos", 32'(first_pos), 32'd448);
        check("fu_period", 32'(second_pos - first_pos), 32'd640);

        // Enable drop on the frame-end tick forces every strobe low at once.
        run_to(15, 9);
        en = 1'b0;
        #1;
        check("hold_fe_pt", 32'(pt4), 32'd0);
        check("hold_fe_le", 32'(le4), 32'd0);
        check("hold_fe_fe", 32'(fe4), 32'd0);
        repeat (3) step();
        check("hold_fe_x", 32'(x4), 32'd15);
        check("hold_fe_y", 32'(y4), 32'd9);
        en = 1'b1;
        #1;
        check("resume_fe_pt", 32'(pt4), 32'd1);
        step();
        check("resume_fe_x", 32'(x4), 32'd0);
        check("resume_fe_y", 32'(y4), 32'd0);

        // Mid-divider hold at (5,3) with DivCnt=1 for 37 clocks.
        run_to(4, 3);
        step();
        step();
        en    = 1'b0;
        ticks = 0;
        repeat (37) begin
            step();
            ticks += 32'(pt4);
        end
        check("hold_ticks", 32'(ticks), 32'd0);
        check("hold_x", 32'(x4), 32'd5);
        check("hold_y", 32'(y4), 32'd3);
        en = 1'b1;
        n  = 0;
        while (!pt4 && (n < 10)) begin
            step();
            n++;
        end
        check("resume_wait", 32'(n), 32'd2);
        check("resume_tick_x", 32'(x4), 32'd5);
        step();
        check("resume_next_x", 32'(x4), 32'd6);
        check("resume_next_y", 32'(y4), 32'd3);

        // Asynchronous reset between edges.
        run_to(10, 6);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_x",  32'(x4),  32'd0);
        check("areset_y",  32'(y4),  32'd0);
        check("areset_pt", 32'(pt4), 32'd0);
        check("areset_fc", 32'(fc4), 32'd0);
        check("areset_x1", 32'(x1),  32'd0);
        step();
        rst_n = 1'b1;

        // CLK_DIV=1: a tick on every enabled cycle, one pixel per clock.
        for (int cyc = 0; cyc < 16; cyc++) begin
            check("div1_tick", 32'(pt1), 32'd1);
            check("div1_x",    32'(x1),  32'(cyc));
            check("div1_le",   32'(le1), 32'(cyc == 15));
            step();
        end
        check("div1_wrap_x", 32'(x1), 32'd0);
        check("div1_wrap_y", 32'(y1), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
